axi_lite_regfile_slave: RTL and testbench

- Parametrised AXI-lite slave holding a bank of NUM_REGS registers, each DATA_W bits wide.
- Next generation of the team's 8-bit single-register AXI-lite block. Adds:
  - configurable width and depth
  - byte write strobes
  - independent AW/W acceptance
  - B/R back-pressure
  - SLVERR for out-of-range addresses
- Sits behind the interconnect as the generic control/status register target.

---
 rtl/axi_lite_regfile_slave.sv | 187 ++++++++++++++++++
 tb/tb_axi_lite_regfile_slave.sv | 309 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/axi_lite_regfile_slave.sv
// AXI-lite slave exposing NUM_REGS registers of DATA_W bits with byte strobes.
// Independent write (AW/W/B) and read (AR/R) FSMs. Out-of-range accesses get SLVERR.
module axi_lite_regfile_slave #(
  parameter int ADDR_W   = 8,
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16
) (
  input  logic                  A_clk,
  input  logic                  A_reset,
  input  logic [ADDR_W-1:0]     AW_addr,
  input  logic                  AW_valid,
  output logic                  AW_ready,
  input  logic [DATA_W-1:0]     W_data,
  input  logic [DATA_W/8-1:0]   W_strb,
  input  logic                  W_valid,
  output logic                  W_ready,
  output logic [1:0]            B_resp,
  output logic                  B_valid,
  input  logic                  B_ready,
  input  logic [ADDR_W-1:0]     AR_addr,
  input  logic                  AR_valid,
  output logic                  AR_ready,
  output logic [DATA_W-1:0]     R_data,
  output logic [1:0]            R_resp,
  output logic                  R_valid,
  input  logic                  R_ready
);

  localparam int              STRB_W     = DATA_W / 8;
  localparam int              OFF_W      = $clog2(STRB_W);
  localparam logic [ADDR_W:0] NUM_REGS_L = (ADDR_W + 1)'(NUM_REGS);
  localparam logic [1:0]      RESP_OKAY  = 2'b00;
  localparam logic [1:0]      RESP_SLV   = 2'b10;

  typedef enum logic [1:0] {WR_IDLE, WR_GOT_AW, WR_GOT_W, WR_RESP} wr_state_t;
  typedef enum logic {RD_IDLE, RD_RESP} rd_state_t;

  logic [DATA_W-1:0] r_regs [NUM_REGS];
  wr_state_t         r_wr_state;
  rd_state_t         r_rd_state;
  logic [ADDR_W-1:0] r_aw_addr;
  logic [DATA_W-1:0] r_w_data;
  logic [STRB_W-1:0] r_w_strb;

  logic              w_aw_hs;
  logic              w_w_hs;
  logic              w_ar_hs;
  logic              w_commit;
  logic [ADDR_W-1:0] w_cmt_addr;
  logic [DATA_W-1:0] w_cmt_data;
  logic [STRB_W-1:0] w_cmt_strb;
  logic [ADDR_W-1:0] w_wr_idx;
  logic              w_wr_ok;
  logic [ADDR_W-1:0] w_rd_idx;
  logic              w_rd_ok;
  logic [DATA_W-1:0] w_rd_data;

  assign w_aw_hs = AW_valid && AW_ready;
  assign w_w_hs  = W_valid && W_ready;
  assign w_ar_hs = AR_valid && AR_ready;

  // The commit uses whichever half of the write was captured earlier plus the live half.
  always_comb begin
    w_commit   = 1'b0;
    w_cmt_addr = AW_addr;
    w_cmt_data = W_data;
    w_cmt_strb = W_strb;
    case (r_wr_state)
      WR_IDLE:   w_commit = w_aw_hs && w_w_hs;
      WR_GOT_AW: begin
        w_commit   = w_w_hs;
        w_cmt_addr = r_aw_addr;
      end
      WR_GOT_W:  begin
        w_commit   = w_aw_hs;
        w_cmt_data = r_w_data;
        w_cmt_strb = r_w_strb;
      end
      default:   w_commit = 1'b0;
    endcase
  end

  assign w_wr_idx = w_cmt_addr >> OFF_W;
  assign w_wr_ok  = {1'b0, w_wr_idx} < NUM_REGS_L;
  assign w_rd_idx = AR_addr >> OFF_W;
  assign w_rd_ok  = {1'b0, w_rd_idx} < NUM_REGS_L;

  always_comb begin
    w_rd_data = '0;
    for (int i = 0; i < NUM_REGS; i++) begin
      if (w_rd_idx == ADDR_W'(i)) w_rd_data = r_regs[i];
    end
  end

  always_ff @(posedge A_clk or posedge A_reset) begin
    if (A_reset) begin
      r_wr_state <= WR_IDLE;
      AW_ready   <= 1'b0;
      W_ready    <= 1'b0;
      B_valid    <= 1'b0;
      B_resp     <= RESP_OKAY;
      r_aw_addr  <= '0;
      r_w_data   <= '0;
      r_w_strb   <= '0;
      for (int i = 0; i < NUM_REGS; i++) r_regs[i] <= '0;
    end else begin
      if (w_commit && w_wr_ok) begin
        for (int i = 0; i < NUM_REGS; i++) begin
          for (int b = 0; b < STRB_W; b++) begin
            if (w_wr_idx == ADDR_W'(i) && w_cmt_strb[b])
              r_regs[i][8*b +: 8] <= w_cmt_data[8*b +: 8];
          end
        end
      end

      if (w_commit) begin
        B_valid    <= 1'b1;
        B_resp     <= w_wr_ok ? RESP_OKAY : RESP_SLV;
        AW_ready   <= 1'b0;
        W_ready    <= 1'b0;
        r_wr_state <= WR_RESP;
      end else begin
        case (r_wr_state)
          WR_IDLE: begin
            if (w_aw_hs) begin
              r_aw_addr  <= AW_addr;
              AW_ready   <= 1'b0;
              r_wr_state <= WR_GOT_AW;
            end else if (w_w_hs) begin
              r_w_data   <= W_data;
              r_w_strb   <= W_strb;
              W_ready    <= 1'b0;
              r_wr_state <= WR_GOT_W;
            end else begin
              AW_ready <= 1'b1;
              W_ready  <= 1'b1;
            end
          end
          // Readies reopen on the B handshake so the next write can land on the following edge.
          WR_RESP: begin
            if (B_ready) begin
              B_valid    <= 1'b0;
              AW_ready   <= 1'b1;
              W_ready    <= 1'b1;
              r_wr_state <= WR_IDLE;
            end
          end
          default: ;
        endcase
      end
    end
  end

  // Read data is sampled from r_regs before any same-edge commit lands.
  always_ff @(posedge A_clk or posedge A_reset) begin
    if (A_reset) begin
      r_rd_state <= RD_IDLE;
      AR_ready   <= 1'b0;
      R_valid    <= 1'b0;
      R_data     <= '0;
      R_resp     <= RESP_OKAY;
    end else begin
      case (r_rd_state)
        RD_IDLE: begin
          if (w_ar_hs) begin
            R_data     <= w_rd_data;
            R_resp     <= w_rd_ok ? RESP_OKAY : RESP_SLV;
            R_valid    <= 1'b1;
            AR_ready   <= 1'b0;
            r_rd_state <= RD_RESP;
          end else begin
            AR_ready <= 1'b1;
          end
        end
        RD_RESP: begin
          if (R_ready) begin
            R_valid    <= 1'b0;
            AR_ready   <= 1'b1;
            r_rd_state <= RD_IDLE;
          end
        end
        default: r_rd_state <= RD_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_axi_lite_regfile_slave.sv
// Self-checking bench for axi_lite_regfile_slave (DATA_W=32, NUM_REGS=16).
// Inputs are driven and outputs sampled on the falling edge; expectations come from a register model.
module tb_axi_lite_regfile_slave;

  logic        A_clk = 1'b0;
  logic        A_reset = 1'b1;
  logic [7:0]  AW_addr = '0;
  logic        AW_valid = 1'b0;
  logic        AW_ready;
  logic [31:0] W_data = '0;
  logic [3:0]  W_strb = '0;
  logic        W_valid = 1'b0;
  logic        W_ready;
  logic [1:0]  B_resp;
  logic        B_valid;
  logic        B_ready = 1'b1;
  logic [7:0]  AR_addr = '0;
  logic        AR_valid = 1'b0;
  logic        AR_ready;
  logic [31:0] R_data;
  logic [1:0]  R_resp;
  logic        R_valid;
  logic        R_ready = 1'b1;

  int n_tests = 0;
  int n_fail  = 0;

  logic [31:0] model [16];
  logic [1:0]  exp_b [$];
  logic [33:0] exp_r [$];

  always #5 A_clk = ~A_clk;

  axi_lite_regfile_slave #(.ADDR_W(8), .DATA_W(32), .NUM_REGS(16)) dut (
    .A_clk(A_clk), .A_reset(A_reset),
    .AW_addr(AW_addr), .AW_valid(AW_valid), .AW_ready(AW_ready),
    .W_data(W_data), .W_strb(W_strb), .W_valid(W_valid), .W_ready(W_ready),
    .B_resp(B_resp), .B_valid(B_valid), .B_ready(B_ready),
    .AR_addr(AR_addr), .AR_valid(AR_valid), .AR_ready(AR_ready),
    .R_data(R_data), .R_resp(R_resp), .R_valid(R_valid), .R_ready(R_ready)
  );

  initial begin
    #400000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  function automatic logic [33:0] exp_read(input logic [7:0] a);
    int idx;
    idx = int'(a >> 2);
    if (idx < 16) return {2'b00, model[idx]};
    return {2'b10, 32'h0};
  endfunction

  function automatic logic [1:0] model_write(input logic [7:0] a, input logic [31:0] d,
                                             input logic [3:0] s);
    int idx;
    idx = int'(a >> 2);
    if (idx >= 16) return 2'b10;
    for (int b = 0; b < 4; b++)
      if (s[b]) model[idx][8*b +: 8] = d[8*b +: 8];
    return 2'b00;
  endfunction

  // lead > 0: W first by lead cycles; lead < 0: AW first; 0: same cycle.
  task automatic do_write(input string name, input logic [7:0] a, input logic [31:0] d,
                          input logic [3:0] s, input int lead);
    int t;
    int gap;
    logic [1:0] e;
    gap = (lead < 0) ? -lead : lead;
    t = 0;
    while ((AW_ready !== 1'b1 || W_ready !== 1'b1) && t < 20) begin @(negedge A_clk); t++; end
    W_data = d; W_strb = s; AW_addr = a;
    if (lead > 0) W_valid = 1'b1;
    else if (lead < 0) AW_valid = 1'b1;
    if (lead != 0) begin
      @(negedge A_clk);
      W_valid = 1'b0; AW_valid = 1'b0;
      n_tests++;
      if (lead > 0 && (W_ready !== 1'b0 || AW_ready !== 1'b1)) begin
        n_fail++;
        $display("FAIL %s w_first_ready: W_ready=%b AW_ready=%b expected 0 1", name, W_ready, AW_ready);
      end
      if (lead < 0 && (AW_ready !== 1'b0 || W_ready !== 1'b1)) begin
        n_fail++;
        $display("FAIL %s aw_first_ready: AW_ready=%b W_ready=%b expected 0 1", name, AW_ready, W_ready);
      end
      repeat (gap - 1) @(negedge A_clk);
      n_tests++;
      if (B_valid !== 1'b0) begin
        n_fail++;
        $display("FAIL %s early_b: B_valid=%b expected 0", name, B_valid);
      end
    end
    AW_valid = 1'b1; W_valid = 1'b1;
    if (lead > 0) AW_valid = 1'b1; else if (lead < 0) W_valid = 1'b1;
    if (lead > 0) W_valid = 1'b0;
    if (lead < 0) AW_valid = 1'b0;
    exp_b.push_back(model_write(a, d, s));
    @(negedge A_clk);
    AW_valid = 1'b0; W_valid = 1'b0;
    n_tests++;
    if (B_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s b_latency: B_valid=%b expected 1", name, B_valid);
    end
    t = 0;
    while (B_valid !== 1'b1 && t < 20) begin @(negedge A_clk); t++; end
    e = exp_b.pop_front();
    n_tests++;
    if (B_resp !== e) begin
      n_fail++;
      $display("FAIL %s b_resp: got %b expected %b", name, B_resp, e);
    end
    @(negedge A_clk);
    n_tests++;
    if (B_valid !== 1'b0 || AW_ready !== 1'b1 || W_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL %s b_done: B_valid=%b AW_ready=%b W_ready=%b expected 0 1 1",
               name, B_valid, AW_ready, W_ready);
    end
  endtask

  task automatic do_read(input string name, input logic [7:0] a);
    int t;
    logic [33:0] e;
    t = 0;
    while (AR_ready !== 1'b1 && t < 20) begin @(negedge A_clk); t++; end
    AR_addr = a; AR_valid = 1'b1;
    exp_r.push_back(exp_read(a));
    @(negedge A_clk);
    AR_valid = 1'b0;
    n_tests++;
    if (R_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL %s r_latency: R_valid=%b expected 1", name, R_valid);
    end
    t = 0;
    while (R_valid !== 1'b1 && t < 20) begin @(negedge A_clk); t++; end
    e = exp_r.pop_front();
    n_tests++;
    if (R_data !== e[31:0] || R_resp !== e[33:32]) begin
      n_fail++;
      $display("FAIL %s r_payload: got %h/%b expected %h/%b", name, R_data, R_resp, e[31:0], e[33:32]);
    end
    @(negedge A_clk);
  endtask

  task automatic test_reset();
    repeat (3) @(negedge A_clk);
    n_tests++;
    if (AW_ready !== 1'b0 || W_ready !== 1'b0 || AR_ready !== 1'b0 || B_valid !== 1'b0 ||
        R_valid !== 1'b0 || R_data !== 32'h0 || B_resp !== 2'b00 || R_resp !== 2'b00) begin
      n_fail++;
      $display("FAIL reset_hold: AWr=%b Wr=%b ARr=%b Bv=%b Rv=%b Rd=%h expected all 0",
               AW_ready, W_ready, AR_ready, B_valid, R_valid, R_data);
    end
    A_reset = 1'b0;
    @(negedge A_clk);
    n_tests++;
    if (AW_ready !== 1'b1 || W_ready !== 1'b1 || AR_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release: AWr=%b Wr=%b ARr=%b expected 1 1 1", AW_ready, W_ready, AR_ready);
    end
    do_read("reset_rd08", 8'h08);
    // Mid-transaction reset with both responses stalled.
    R_ready = 1'b0; B_ready = 1'b0;
    AR_addr = 8'h08; AR_valid = 1'b1;
    AW_addr = 8'h04; W_data = 32'h1111_2222; W_strb = 4'hF; AW_valid = 1'b1; W_valid = 1'b1;
    @(negedge A_clk);
    AR_valid = 1'b0; AW_valid = 1'b0; W_valid = 1'b0;
    n_tests++;
    if (R_valid !== 1'b1 || B_valid !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_pre: R_valid=%b B_valid=%b expected 1 1", R_valid, B_valid);
    end
    #2 A_reset = 1'b1;
    #1;
    n_tests++;
    if (R_valid !== 1'b0 || B_valid !== 1'b0 || AW_ready !== 1'b0 || AR_ready !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_async: R_valid=%b B_valid=%b AWr=%b ARr=%b expected 0 0 0 0",
               R_valid, B_valid, AW_ready, AR_ready);
    end
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    exp_b.delete(); exp_r.delete();
    repeat (2) @(negedge A_clk);
    R_ready = 1'b1; B_ready = 1'b1;
    A_reset = 1'b0;
    @(negedge A_clk);
    do_read("reset_after_rd08", 8'h08);
    do_read("reset_after_rd04", 8'h04);
  endtask

  task automatic test_simul_write();
    do_write("simul_wr08", 8'h08, 32'hDEAD_BEEF, 4'hF, 0);
    do_read("simul_rd08", 8'h08);
  endtask

  task automatic test_staggered();
    do_write("stag_wfirst", 8'h08, 32'h0000_00AA, 4'b0001, 3);
    do_read("stag_rd08", 8'h08);
    n_tests++;
    if (model[2] !== 32'hDEAD_BEAA) begin
      n_fail++;
      $display("FAIL stag_model: got %h expected deadbeaa", model[2]);
    end
    do_write("stag_awfirst", 8'h14, 32'hA5A5_5A5A, 4'b1010, -2);
    do_read("stag_rd14", 8'h14);
    do_write("stag_nostrb", 8'h08, 32'hFFFF_FFFF, 4'b0000, 0);
    do_read("stag_rd08_nostrb", 8'h0B);
  endtask

  task automatic test_out_of_range();
    do_write("oor_wr40", 8'h40, 32'hFFFF_FFFF, 4'hF, 0);
    do_write("oor_wrFC", 8'hFC, 32'h1234_5678, 4'hF, 1);
    do_read("oor_rd40", 8'h40);
    do_read("oor_rdFF", 8'hFF);
    for (int i = 0; i < 16; i++) do_read("oor_scan", 8'(i * 4));
  endtask

  task automatic test_backpressure();
    logic [1:0]  eb;
    logic [33:0] er;
    B_ready = 1'b0; R_ready = 1'b0;
    AW_addr = 8'h10; W_data = 32'h55AA_00FF; W_strb = 4'hF; AW_valid = 1'b1; W_valid = 1'b1;
    AR_addr = 8'h08; AR_valid = 1'b1;
    exp_r.push_back(exp_read(8'h08));
    exp_b.push_back(model_write(8'h10, 32'h55AA_00FF, 4'hF));
    @(negedge A_clk);
    AW_valid = 1'b0; W_valid = 1'b0; AR_valid = 1'b0;
    eb = exp_b.pop_front();
    er = exp_r.pop_front();
    for (int c = 0; c < 5; c++) begin
      n_tests++;
      if (B_valid !== 1'b1 || B_resp !== eb || R_valid !== 1'b1 || R_data !== er[31:0] ||
          R_resp !== er[33:32] || AW_ready !== 1'b0 || W_ready !== 1'b0 || AR_ready !== 1'b0) begin
        n_fail++;
        $display("FAIL bp_hold cyc%0d: Bv=%b Br=%b Rv=%b Rd=%h Rr=%b rdy=%b%b%b expected 1 %b 1 %h %b 000",
                 c, B_valid, B_resp, R_valid, R_data, R_resp, AW_ready, W_ready, AR_ready,
                 eb, er[31:0], er[33:32]);
      end
      if (c < 4) @(negedge A_clk);
    end
    B_ready = 1'b1; R_ready = 1'b1;
    @(negedge A_clk);
    n_tests++;
    if (B_valid !== 1'b0 || R_valid !== 1'b0 || AW_ready !== 1'b1 || AR_ready !== 1'b1) begin
      n_fail++;
      $display("FAIL bp_release: Bv=%b Rv=%b AWr=%b ARr=%b expected 0 0 1 1",
               B_valid, R_valid, AW_ready, AR_ready);
    end
    do_read("bp_rd10", 8'h10);
  endtask

  task automatic test_collision();
    logic [1:0]  eb;
    logic [33:0] er;
    AW_addr = 8'h0C; W_data = 32'h1234_5678; W_strb = 4'hF; AW_valid = 1'b1; W_valid = 1'b1;
    AR_addr = 8'h0C; AR_valid = 1'b1;
    exp_r.push_back(exp_read(8'h0C));
    exp_b.push_back(model_write(8'h0C, 32'h1234_5678, 4'hF));
    @(negedge A_clk);
    AW_valid = 1'b0; W_valid = 1'b0; AR_valid = 1'b0;
    eb = exp_b.pop_front();
    er = exp_r.pop_front();
    n_tests++;
    if (R_valid !== 1'b1 || R_data !== er[31:0] || R_resp !== er[33:32]) begin
      n_fail++;
      $display("FAIL coll_old: Rv=%b Rd=%h Rr=%b expected 1 %h %b", R_valid, R_data, R_resp,
               er[31:0], er[33:32]);
    end
    n_tests++;
    if (B_valid !== 1'b1 || B_resp !== eb) begin
      n_fail++;
      $display("FAIL coll_b: Bv=%b Br=%b expected 1 %b", B_valid, B_resp, eb);
    end
    @(negedge A_clk);
    do_read("coll_new", 8'h0C);
  endtask

  task automatic test_back_to_back();
    logic [7:0] a;
    int lead;
    for (int n = 0; n < 24; n++) begin
      a = 8'($urandom_range(0, 8'h4F));
      lead = int'($urandom_range(0, 4)) - 2;
      do_write("b2b_wr", a, $urandom, 4'($urandom_range(0, 15)), lead);
      do_read("b2b_rd_same", a);
      do_read("b2b_rd_any", 8'($urandom_range(0, 8'h4F)));
    end
  endtask

  initial begin
    for (int i = 0; i < 16; i++) model[i] = 32'h0;
    test_reset();
    test_simul_write();
    test_staggered();
    test_out_of_range();
    test_backpressure();
    test_collision();
    test_back_to_back();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
